// File: rtl/prbs9_checker.sv
// PRBS9 (x^9 + x^5 + 1) receive checker: self-synchronising search/verify/locked FSM with bit-error counting.
// Optional macro PRBS9_CHK_SAT_EN makes err_count saturate instead of wrapping.
module prbs9_checker #(
   parameter int unsigned ERR_W    = 16,
   parameter int unsigned LOCK_CNT = 16,
   parameter int unsigned LOSS_THR = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_in_valid,
   input  logic             i_in_bit,
   input  logic             i_clr_count,
   output logic             o_locked,
   output logic             o_err_pulse,
   output logic [ERR_W-1:0] o_err_count,
   output logic [1:0]       o_state
);

   localparam int unsigned FILL_W  = 4;
   localparam int unsigned MATCH_W = 8;
   localparam int unsigned MISS_W  = 4;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t             r_state;
   logic [8:0]         r_h;
   logic [FILL_W-1:0]  r_fill_cnt;
   logic [MATCH_W-1:0] r_match_cnt;
   logic [MISS_W-1:0]  r_miss_cnt;
   logic [ERR_W-1:0]   r_err_count;
   logic               r_err_pulse;
   logic               r_locked;

   state_t             w_state_nxt;
   logic [8:0]         w_h_nxt;
   logic [8:0]         w_h_rx;
   logic [FILL_W-1:0]  w_fill_nxt;
   logic [MATCH_W-1:0] w_match_nxt;
   logic [MISS_W-1:0]  w_miss_nxt;
   logic [ERR_W-1:0]   w_err_count_nxt;
   logic               w_err_inc;
   logic               w_pred;

   assign w_pred = r_h[8] ^ r_h[4];
   assign w_h_rx = {r_h[7:0], i_in_bit};

   // State register and all registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= SEARCH;
         r_h         <= '0;
         r_fill_cnt  <= '0;
         r_match_cnt <= '0;
         r_miss_cnt  <= '0;
         r_err_count <= '0;
         r_err_pulse <= 1'b0;
         r_locked    <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_h         <= w_h_nxt;
         r_fill_cnt  <= w_fill_nxt;
         r_match_cnt <= w_match_nxt;
         r_miss_cnt  <= w_miss_nxt;
         r_err_count <= w_err_count_nxt;
         r_err_pulse <= w_err_inc;
         r_locked    <= (w_state_nxt == LOCKED);
      end
   end

   // Next-state, history and counter logic.
   always_comb begin
      w_state_nxt = r_state;
      w_h_nxt     = r_h;
      w_fill_nxt  = r_fill_cnt;
      w_match_nxt = r_match_cnt;
      w_miss_nxt  = r_miss_cnt;
      w_err_inc   = 1'b0;

      if (i_in_valid) begin
         unique case (r_state)
            SEARCH: begin
               w_h_nxt    = w_h_rx;
               w_fill_nxt = r_fill_cnt + FILL_W'(1);
               if (r_fill_cnt == FILL_W'(8)) begin
                  w_fill_nxt = '0;
                  if (w_h_rx != 9'd0) begin
                     w_state_nxt = VERIFY;
                     w_match_nxt = '0;
                  end
               end
            end
            VERIFY: begin
               w_h_nxt = w_h_rx;
               if (i_in_bit == w_pred) begin
                  w_match_nxt = r_match_cnt + MATCH_W'(1);
                  if (r_match_cnt == MATCH_W'(LOCK_CNT - 1)) begin
                     w_state_nxt = LOCKED;
                     w_miss_nxt  = '0;
                  end
               end else begin
                  w_state_nxt = SEARCH;
                  w_fill_nxt  = '0;
                  w_match_nxt = '0;
               end
            end
            LOCKED: begin
               // Flywheel: history advances on the prediction, never the received bit.
               w_h_nxt = {r_h[7:0], w_pred};
               if (i_in_bit != w_pred) begin
                  w_err_inc  = 1'b1;
                  w_miss_nxt = r_miss_cnt + MISS_W'(1);
                  if (r_miss_cnt == MISS_W'(LOSS_THR - 1)) begin
                     w_state_nxt = SEARCH;
                     w_fill_nxt  = '0;
                  end
               end else begin
                  w_miss_nxt = '0;
               end
            end
            default: begin
               w_state_nxt = SEARCH;
               w_fill_nxt  = '0;
            end
         endcase
      end
   end

   // Error counter: clear wins over a same-cycle increment.
   always_comb begin
      w_err_count_nxt = r_err_count;
      if (i_clr_count) begin
         w_err_count_nxt = '0;
      end else if (w_err_inc) begin
`ifdef PRBS9_CHK_SAT_EN
         if (!(&r_err_count)) w_err_count_nxt = r_err_count + ERR_W'(1);
`else
         w_err_count_nxt = r_err_count + ERR_W'(1);
`endif
      end
   end

   assign o_locked    = r_locked;
   assign o_err_pulse = r_err_pulse;
   assign o_err_count = r_err_count;
   assign o_state     = r_state;

endmodule

// File: tb/tb_prbs9_checker.sv
// Directed self-checking bench for prbs9_checker (default build and PRBS9_CHK_SAT_EN build).
module tb_prbs9_checker;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_bit = 1'b0;
   logic        clr_count = 1'b0;
   logic        locked, err_pulse, locked2, err_pulse2;
   logic [15:0] err_count;
   logic [1:0]  err_count2;
   logic [1:0]  state, state2;

   int n_cmp = 0;
   int n_bad = 0;
   logic [8:0] g;
   logic       b;
   int         pulses;

   always #5 clk = ~clk;

   prbs9_checker dut (
      .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .i_in_bit(in_bit),
      .i_clr_count(clr_count), .o_locked(locked), .o_err_pulse(err_pulse),
      .o_err_count(err_count), .o_state(state)
   );

   prbs9_checker #(.ERR_W(2)) dut2 (
      .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .i_in_bit(in_bit),
      .i_clr_count(clr_count), .o_locked(locked2), .o_err_pulse(err_pulse2),
      .o_err_count(err_count2), .o_state(state2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference generator: emit g[8], shift in g[8]^g[4].
   task automatic gen(output logic bo);
      bo = g[8];
      g  = {g[7:0], g[8] ^ g[4]};
   endtask

   task automatic cyc(input logic r, input logic v, input logic bi, input logic c);
      @(negedge clk);
      rst = r; in_valid = v; in_bit = bi; clr_count = c;
      @(posedge clk);
      #1;
   endtask

   task automatic send_gen(input logic flip, input logic c);
      logic gb;
      gen(gb);
      cyc(1'b0, 1'b1, gb ^ flip, c);
   endtask

   task automatic do_reset();
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      g = 9'h1FF;
   endtask

   initial begin
      // Reset values
      do_reset();
      chk("rst_state", 32'(state), 0);
      chk("rst_locked", 32'(locked), 0);
      chk("rst_pulse", 32'(err_pulse), 0);
      chk("rst_count", 32'(err_count), 0);

      // Lock from reset: VERIFY after bit 9, LOCKED after bit 25
      for (int k = 1; k <= 25; k++) begin
         send_gen(1'b0, 1'b0);
         chk("lock_state", 32'(state), (k < 9) ? 0 : (k < 25) ? 1 : 2);
         chk("lock_locked", 32'(locked), (k == 25) ? 1 : 0);
         chk("lock_pulse", 32'(err_pulse), 0);
      end
      chk("lock_count", 32'(err_count), 0);

      // Single error
      send_gen(1'b1, 1'b0);
      chk("single_pulse", 32'(err_pulse), 1);
      chk("single_count", 32'(err_count), 1);
      chk("single_locked", 32'(locked), 1);
      pulses = 0;
      for (int k = 0; k < 100; k++) begin
         send_gen(1'b0, 1'b0);
         if (err_pulse) pulses++;
      end
      chk("single_nopulse", 32'(pulses), 0);
      chk("single_count2", 32'(err_count), 1);
      chk("single_locked2", 32'(locked), 1);

      // Clear with idle input, then loss of lock
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      chk("clr_count", 32'(err_count), 0);
      chk("clr_nopulse", 32'(err_pulse), 0);
      for (int k = 1; k <= 4; k++) begin
         send_gen(1'b1, 1'b0);
         chk("loss_pulse", 32'(err_pulse), 1);
         chk("loss_count", 32'(err_count), 32'(k));
         chk("loss_locked", 32'(locked), (k < 4) ? 1 : 0);
      end
      chk("loss_state", 32'(state), 0);
      for (int k = 1; k <= 25; k++) begin
         send_gen(1'b0, 1'b0);
         chk("relock_locked", 32'(locked), (k == 25) ? 1 : 0);
      end
      chk("relock_count", 32'(err_count), 4);

      // All-zero stream never leaves SEARCH
      do_reset();
      for (int k = 0; k < 40; k++) begin
         cyc(1'b0, 1'b1, 1'b0, 1'b0);
         chk("zero_state", 32'(state), 0);
         chk("zero_locked", 32'(locked), 0);
      end

      // Lock with alternating in_valid gaps
      do_reset();
      for (int k = 1; k <= 25; k++) begin
         send_gen(1'b0, 1'b0);
         chk("gap_locked", 32'(locked), (k == 25) ? 1 : 0);
         cyc(1'b0, 1'b0, 1'b1, 1'b0);
         chk("gap_idle_locked", 32'(locked), (k == 25) ? 1 : 0);
         chk("gap_idle_state", 32'(state), (k < 9) ? 0 : (k < 25) ? 1 : 2);
      end
      send_gen(1'b1, 1'b0);
      chk("gap_err_count", 32'(err_count), 1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk("gap_idle_pulse", 32'(err_pulse), 0);
      send_gen(1'b1, 1'b1);
      chk("errclr_pulse", 32'(err_pulse), 1);
      chk("errclr_count", 32'(err_count), 0);
      chk("errclr_locked", 32'(locked), 1);

      // Reset while LOCKED
      send_gen(1'b0, 1'b0);
      send_gen(1'b1, 1'b0);
      chk("pre_rst_count", 32'(err_count), 1);
      cyc(1'b1, 1'b1, 1'b1, 1'b0);
      chk("midrst_locked", 32'(locked), 0);
      chk("midrst_count", 32'(err_count), 0);
      chk("midrst_state", 32'(state), 0);
      chk("midrst_pulse", 32'(err_pulse), 0);

      // Narrow counter: 5 isolated errors
      do_reset();
      for (int k = 1; k <= 25; k++) send_gen(1'b0, 1'b0);
      chk("w2_locked", 32'(locked2), 1);
      for (int e = 1; e <= 5; e++) begin
         send_gen(1'b1, 1'b0);
         chk("w2_pulse", 32'(err_pulse2), 1);
         for (int k = 0; k < 3; k++) send_gen(1'b0, 1'b0);
      end
`ifdef PRBS9_CHK_SAT_EN
      chk("w2_count", 32'(err_count2), 3);
`else
      chk("w2_count", 32'(err_count2), 1);
`endif
      chk("w16_count", 32'(err_count), 5);
      chk("w2_locked_end", 32'(locked2), 1);

      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/prbs9_checker.md
Name: prbs9_checker

Overview:
- Receive-side counterpart of the 9-bit LFSR pattern generator. Accepts the generator's serial PRBS9 stream (x^9 + x^5 + 1) one bit per valid cycle.
- Self-synchronises a local LFSR to the incoming stream, declares lock, then counts bit errors.
- Sits at the receive end of the link-test path. Drives lock status and error statistics to the test harness or status registers.

Parameters:
- ERR_W, 16: width of the error counter.
- LOCK_CNT, 16: consecutive correct predictions needed in VERIFY to declare lock (range 1..255).
- LOSS_THR, 4: consecutive mismatches in LOCKED that cause loss of lock (range 1..15).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_bit is valid this cycle; when low, no state change.
- in_bit  input  1  received serial PRBS bit.
- clr_count  input  1  synchronous clear of err_count.
- locked  output  1  high while in LOCKED state.
- err_pulse  output  1  one-cycle pulse per counted bit error.
- err_count  output  ERR_W  accumulated bit errors while LOCKED.
- state  output  2  current FSM state: 0=SEARCH, 1=VERIFY, 2=LOCKED.

Behaviour:
- Reset values (reset is synchronous):
  - state=SEARCH; history h[8:0]=0; fill_cnt=0; match_cnt=0; miss_cnt=0.
  - locked=0, err_pulse=0, err_count=0.
  - rst overrides every other input, including during LOCKED.
- Prediction: h[0] is the newest bit. pred = h[8] ^ h[4].
- All outputs are registered and reflect the effect of a valid bit in the cycle after it is accepted.
- err_pulse is 0 on every cycle with no counted error, including in_valid=0 cycles.
- SEARCH:
  - Each valid bit: h <= {h[7:0], in_bit}; fill_cnt++.
  - On the 9th accepted bit: if the new h != 0, go to VERIFY with match_cnt=0.
  - If the new h == 0 (illegal PRBS9 state), stay in SEARCH with fill_cnt=0.
- VERIFY:
  - Each valid bit: h <= {h[7:0], in_bit}.
  - If in_bit == pred: match_cnt++. The LOCK_CNT-th match moves the FSM to LOCKED with miss_cnt=0.
  - If in_bit != pred: go to SEARCH with fill_cnt=0, match_cnt=0.
  - Errors are not counted in VERIFY.
- LOCKED (flywheel):
  - Each valid bit: h <= {h[7:0], pred}. The received bit never enters the history, so one flipped bit gives exactly one error.
  - Mismatch: err_pulse=1, err_count++, miss_cnt++.
  - Match: miss_cnt=0.
  - When miss_cnt reaches LOSS_THR: go to SEARCH with fill_cnt=0. locked falls in the same cycle that the final err_pulse rises; that last error is counted.
- Lock timing: with a clean stream from reset, locked rises the cycle after the (9+LOCK_CNT)-th valid bit, i.e. the 25th with defaults.
- err_count:
  - Wraps modulo 2^ERR_W (see Optional Feature).
  - clr_count has priority over a same-cycle increment: result is 0 and err_pulse still fires.
  - err_count holds across lock loss; only rst or clr_count clear it.
- in_valid gaps of any length have no effect on counters or the FSM.

Optional Feature:
- Macro: PRBS9_CHK_SAT_EN.
- Defined: err_count saturates at 2^ERR_W-1. Further errors still pulse err_pulse but do not change the count.
- Undefined: err_count wraps to 0 after 2^ERR_W-1.

Test Plan:
- Lock from reset: rst, then 25 valid bits of clean PRBS9 from generator seed 9'h1FF -> state 0 for bits 1-9, 1 for bits 10-25; locked=1 the cycle after bit 25; err_count=0; err_pulse never high.
- Single error: after lock, invert one bit -> err_pulse high exactly 1 cycle; err_count=1; locked stays 1; next 100 clean bits give no further pulses.
- Loss of lock: after lock, invert 4 consecutive bits -> err_count=4; locked=0 the cycle after the 4th; then 25 clean bits -> locked=1 again; err_count still 4.
- All-zero stream: 40 valid zero bits after reset -> state stays SEARCH; locked=0 throughout.
- Gaps and clear: repeat the lock test with in_valid low on alternating cycles -> locked after the 25th valid bit; then an error and clr_count in the same cycle -> err_pulse=1, err_count=0.
- Reset and counter width: rst mid-LOCKED -> next cycle locked=0, err_count=0, state=0. Separately, ERR_W=2 with 5 isolated errors while locked -> err_count=3 with PRBS9_CHK_SAT_EN defined, 1 without.
